// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush sequencer for the 5-stage RISC-V core
// Covers load-use stalls, taken-branch flushes, multi-cycle EX ops and imem wait states.
module hazard_ctrl #(
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic [4:0]       rd_EX,
  input  logic             MemRead_EX,
  input  logic             branch_taken_EX,
  input  logic             mc_start_EX,
  input  logic             mc_done,
  input  logic             imem_ready,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_bubble,
  output logic             ID_EX_hold,
  output logic             EX_MEM_bubble,
  output logic             mc_error,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int TW = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;

  typedef enum logic {RUN, MC_BUSY} state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             mc_error_q, mc_error_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             load_use;

  assign load_use = MemRead_EX && (rd_EX != 5'd0) &&
                    ((rd_EX == rs1_ID) || (rd_EX == rs2_ID));

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    mc_error_d    = mc_error_q;
    stall_d       = stall_q;
    PC_write      = 1'b1;
    IF_ID_write   = 1'b1;
    IF_ID_flush   = 1'b0;
    ID_EX_bubble  = 1'b0;
    ID_EX_hold    = 1'b0;
    EX_MEM_bubble = 1'b0;

    if (reset) begin
      PC_write      = 1'b0;
      IF_ID_write   = 1'b0;
      IF_ID_flush   = 1'b1;
      ID_EX_bubble  = 1'b1;
      EX_MEM_bubble = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (branch_taken_EX) begin
            IF_ID_flush  = 1'b1;
            ID_EX_bubble = 1'b1;
          end else if (mc_start_EX) begin
            PC_write      = 1'b0;
            IF_ID_write   = 1'b0;
            ID_EX_hold    = 1'b1;
            EX_MEM_bubble = 1'b1;
            state_d       = MC_BUSY;
            timer_d       = '0;
          end else if (load_use) begin
            PC_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_bubble = 1'b1;
          end else if (!imem_ready) begin
            PC_write    = 1'b0;
            IF_ID_flush = 1'b1;
          end
        end
        MC_BUSY: begin
          PC_write      = 1'b0;
          IF_ID_write   = 1'b0;
          ID_EX_hold    = 1'b1;
          EX_MEM_bubble = 1'b1;
          timer_d       = timer_q + 1'b1;
          // A result arriving on the last allowed cycle still wins over the abort.
          if (mc_done) begin
            EX_MEM_bubble = 1'b0;
            state_d       = RUN;
          end else if (timer_q == TW'(MC_TIMEOUT - 1)) begin
            mc_error_d = 1'b1;
            state_d    = RUN;
          end
        end
        default: state_d = RUN;
      endcase

      if (!PC_write && (stall_q != {CNT_W{1'b1}})) begin
        stall_d = stall_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      timer_q    <= '0;
      mc_error_q <= 1'b0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      mc_error_q <= mc_error_d;
      stall_q    <= stall_d;
    end
  end

  assign mc_error     = mc_error_q;
  assign stall_cycles = stall_q;

endmodule
